// File: rtl/alu_displays_block.sv
// Unsigned 4-op ALU with registered flags driving a
// 4-digit multiplexed active-low 7-segment display.
module alu_displays_block #(
  parameter int WIDTH        = 3,
  parameter int REFRESH_BITS = 16
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       op,
  output logic [3:0]       select_disp,
  output logic             zero,
  output logic             error,
  output logic             AE,
  output logic             BE,
  output logic             CE,
  output logic             DE,
  output logic             EE,
  output logic             FE,
  output logic             GE
);

  localparam int MW = 2 * WIDTH;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_R     = 7'b1111010;

  logic [MW-1:0] w_a;
  logic [MW-1:0] w_b;
  logic [MW-1:0] w_mag;
  logic          w_sign;
  logic          w_err;

  logic [MW-1:0] r_mag;
  logic          r_sign;
  logic          r_err;
  logic          r_zero;

  logic [REFRESH_BITS-1:0] r_cnt;
  logic [1:0]              r_idx;

  logic [9:0] w_val;
  logic [9:0] w_hun;
  logic [9:0] w_ten;
  logic [9:0] w_one;
  logic [6:0] w_seg;

  assign w_a = MW'(in1);
  assign w_b = MW'(in2);

  function automatic logic [6:0] f_digit(input logic [9:0] d);
    logic [6:0] s;
    case (d)
      10'd0:   s = 7'b0000001;
      10'd1:   s = 7'b1001111;
      10'd2:   s = 7'b0010010;
      10'd3:   s = 7'b0000110;
      10'd4:   s = 7'b1001100;
      10'd5:   s = 7'b0100100;
      10'd6:   s = 7'b0100000;
      10'd7:   s = 7'b0001111;
      10'd8:   s = 7'b0000000;
      10'd9:   s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // combinational ALU: magnitude, sign of subtract, div-by-zero
  always_comb begin
    w_mag  = '0;
    w_sign = 1'b0;
    w_err  = 1'b0;
    unique case (op)
      2'b00: w_mag = w_a + w_b;
      2'b01: begin
        if (w_a < w_b) begin
          w_sign = 1'b1;
          w_mag  = w_b - w_a;
        end else begin
          w_mag  = w_a - w_b;
        end
      end
      2'b10: w_mag = w_a * w_b;
      2'b11: begin
        if (w_b == '0) w_err = 1'b1;
        else           w_mag = w_a / w_b;
      end
    endcase
  end

  // result and flag registers
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_mag  <= '0;
      r_sign <= 1'b0;
      r_err  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_mag  <= w_mag;
      r_sign <= w_sign;
      r_err  <= w_err;
      r_zero <= (w_mag == '0) && !w_err;
    end
  end

  // refresh counter; digit index steps on each wrap
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) r_idx <= r_idx + 2'd1;
    end
  end

  assign w_val = 10'(r_mag);
  assign w_hun = w_val / 10'd100;
  assign w_ten = (w_val / 10'd10) % 10'd10;
  assign w_one = w_val % 10'd10;

  // segment pattern for the currently enabled digit
  always_comb begin
    w_seg = SEG_BLANK;
    unique case (r_idx)
      2'd0: w_seg = r_err ? SEG_BLANK : f_digit(w_one);
      2'd1: begin
        if (r_err)
          w_seg = SEG_R;
        else if (w_hun == 10'd0 && w_ten == 10'd0)
          w_seg = SEG_BLANK;
        else
          w_seg = f_digit(w_ten);
      end
      2'd2: begin
        if (r_err)
          w_seg = SEG_R;
        else if (w_hun == 10'd0)
          w_seg = SEG_BLANK;
        else
          w_seg = f_digit(w_hun);
      end
      2'd3: begin
        if (r_err)       w_seg = SEG_E;
        else if (r_sign) w_seg = SEG_DASH;
        else             w_seg = SEG_BLANK;
      end
    endcase
  end

  assign select_disp = ~(4'b0001 << r_idx);
  assign {AE, BE, CE, DE, EE, FE, GE} = w_seg;
  assign zero  = r_zero;
  assign error = r_err;

endmodule

// File: tb/tb_alu_displays_block.sv
// Scoreboard bench: driver queues expected display state,
// monitor pops one entry per clock edge and compares.
module tb_alu_displays_block;

  localparam int W = 3;
  localparam int R = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [1:0]   op = 2'b00;
  logic [3:0]   select_disp;
  logic         zero;
  logic         error;
  logic         AE, BE, CE, DE, EE, FE, GE;

  typedef struct packed {
    logic        z;
    logic        e;
    logic [1:0]  idx;
    logic [27:0] segs;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  bit   done = 0;

  logic [6:0] DIG [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
                           7'b0000110, 7'b1001100, 7'b0100100,
                           7'b0100000, 7'b0001111, 7'b0000000,
                           7'b0000100};
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;
  localparam logic [6:0] EC = 7'b0110000;
  localparam logic [6:0] RC = 7'b1111010;

  alu_displays_block #(.WIDTH(W), .REFRESH_BITS(R)) dut (
    .mclk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op),
    .select_disp(select_disp), .zero(zero), .error(error),
    .AE(AE), .BE(BE), .CE(CE), .DE(DE), .EE(EE), .FE(FE), .GE(GE)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(bit r, int a, int b, int o, int kk);
    exp_t x;
    int v, h, t, u;
    bit s, e;
    logic [6:0] d0, d1, d2, d3;
    v = 0; s = 0; e = 0;
    if (!r) begin
      case (o)
        0: v = a + b;
        1: begin s = (a < b); v = s ? b - a : a - b; end
        2: v = a * b;
        default: if (b == 0) e = 1; else v = a / b;
      endcase
    end
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    if (e) begin
      d3 = EC; d2 = RC; d1 = RC; d0 = BL;
    end else begin
      d0 = DIG[u];
      d1 = (h == 0 && t == 0) ? BL : DIG[t];
      d2 = (h == 0) ? BL : DIG[h];
      d3 = s ? DS : BL;
    end
    x.z    = !r && v == 0 && !e;
    x.e    = e;
    x.idx  = 2'((kk >> R) & 3);
    x.segs = {d3, d2, d1, d0};
    return x;
  endfunction

  task automatic apply(bit r, int a, int b, int o, int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; in1 = W'(a); in2 = W'(b); op = 2'(o);
      if (r) k = 0; else k++;
      q.push_back(model(r, a, b, o, k));
    end
  endtask

  // monitor: one expected entry per edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      logic [27:0] sg;
      logic [6:0] want, got;
      logic [3:0] wsel;
      x = q.pop_front();
      sg = x.segs;
      want = sg[x.idx*7 +: 7];
      got = {AE, BE, CE, DE, EE, FE, GE};
      wsel = ~(4'b0001 << x.idx);
      checks++;
      if (zero !== x.z) begin
        errors++;
        $display("FAIL zero: got %b want %b t=%0t", zero, x.z, $time);
      end
      checks++;
      if (error !== x.e) begin
        errors++;
        $display("FAIL error: got %b want %b t=%0t", error, x.e, $time);
      end
      checks++;
      if (select_disp !== wsel) begin
        errors++;
        $display("FAIL select: got %b want %b t=%0t", select_disp, wsel, $time);
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL seg d%0d: got %b want %b t=%0t", x.idx, got, want, $time);
      end
    end
  end

  initial begin
    apply(1, 0, 0, 0, 2);
    apply(0, 3, 1, 0, 8);
    apply(0, 5, 2, 1, 8);
    apply(0, 1, 3, 1, 8);
    apply(0, 2, 2, 2, 8);
    apply(0, 7, 7, 2, 8);
    apply(0, 2, 2, 1, 3);
    apply(0, 4, 2, 3, 8);
    apply(0, 4, 0, 3, 8);
    apply(0, 4, 2, 3, 16);
    apply(0, 6, 5, 0, 3);
    apply(1, 6, 5, 0, 1);
    apply(0, 6, 5, 0, 9);
    for (int n = 0; n < 300; n++) begin
      apply(($urandom_range(0, 15) == 0), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(1, 6));
    end
    apply(0, 7, 0, 3, 8);
    apply(0, 0, 0, 0, 2);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_displays_block.md
# alu_displays_block

Block module `ALU_Displays` is a parameterized unsigned 4-function ALU (add, subtract, multiply, divide) with registered `zero`/`error` flags. It drives a 4-digit multiplexed 7-segment display: the decimal result, a minus sign, or an "Err" message. It sits between board switches/buttons (operands, opcode) and the display/LED pins.

## Interface
- `WIDTH`, default 3: operand width in bits; legal range 1..4.
- `REFRESH_BITS`, default 16: width of the display refresh counter; each digit is lit for 2^REFRESH_BITS cycles.
- `mclk` input 1: system clock; all state on the rising edge.
- `rst` input 1: reset; one clock, synchronous, active-high.
- `in1` input WIDTH: operand A, unsigned.
- `in2` input WIDTH: operand B, unsigned.
- `op` input 2: 00 add, 01 subtract, 10 multiply, 11 divide.
- `select_disp` output 4: digit enables, active-low one-hot; bit0 = rightmost digit.
- `zero` output 1: registered result is exactly 0 and no error.
- `error` output 1: registered division by zero.
- `AE`,`BE`,`CE`,`DE`,`EE`,`FE`,`GE` output 1 each: segments a..g of the enabled digit, active-low (0 = lit).

## Operation
- Combinational ALU, 2*WIDTH-bit unsigned magnitude plus a sign bit:
  - add: in1+in2.
  - sub: |in1-in2|; sign=1 when in1<in2.
  - mul: in1*in2.
  - div: floor(in1/in2). When in2==0: error=1, magnitude=0.
- Each rising edge (rst=0) registers magnitude, sign, error, and zero = (magnitude==0 && !error).
- Registered magnitude is converted to 3 decimal digits (hundreds, tens, ones); max value 225 at WIDTH=4.
- Display layout, normal:
  - digit0 = ones, always shown (including "0").
  - digit1 = tens, blank if tens==0 and hundreds==0.
  - digit2 = hundreds, blank if 0.
  - digit3 = '-' when sign=1, else blank.
- Display layout, error=1: digit3 'E', digit2 'r', digit1 'r', digit0 blank.
- Segment codes, AE..GE, active-low:
  - digits: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - symbols: '-'=1111110, blank=1111111, 'E'=0110000, 'r'=1111010.
- Refresh counter (REFRESH_BITS wide) increments every cycle and wraps.
  - A 2-bit digit index advances 0→1→2→3→0 on each counter wrap.
  - select_disp: index 0 = 1110, 1 = 1101, 2 = 1011, 3 = 0111.
  - Segments are decoded combinationally from the registered value and the current index.

## Timing
- Reset, takes effect on the first rising edge with rst=1:
  - magnitude=0, sign=0, error=0, zero=0, refresh counter=0, index=0.
  - Outputs held: select_disp=1110, segments=0000001 ("0"), zero=0, error=0.
- Latency: inputs sampled at edge N; zero, error and the display value update immediately after edge N. Inputs need no hold beyond one edge.
- Input changes between edges have no output effect until the next edge. There is no handshake.
- When rst=1 and inputs change on the same edge, reset wins.
- Reset mid-refresh restarts at digit0 with counter 0.
- Index change and segment change happen after the same edge, so there is no stale-digit cycle beyond combinational settling.
- Outputs other than segments/select never glitch; they are registered.

## Test plan
All scenarios use WIDTH=3, REFRESH_BITS=1 (2 cycles per digit).
- Reset: rst=1 for 2 edges -> select_disp=1110, segments=0000001, zero=0, error=0.
- Add 3+1, op=00 -> after 1 edge zero=0, error=0. Scanning: digit0=1001100 ('4'), digit1..3 blank 1111111.
- Subtract 5-2 -> digit0 '3' (0000110), digit3 blank. Subtract 1-3 -> digit0 '2', digit3 '-' (1111110), zero=0.
- Multiply 2*2 -> '4'. Multiply 7*7 -> digit1 '4', digit0 '9'. Subtract 2-2 -> zero=1.
- Divide 4/2 -> '2'. Divide 4/0 -> error=1, zero=0, digits3..0 = E,r,r,blank. Next edge with in2=2 -> error=0.
- Refresh order: hold any input for 16 cycles -> select_disp sequence 1110,1101,1011,0111 repeating, each held 2 cycles. Assert rst mid-scan -> returns to 1110 on the next edge.
